// File: rtl/doc5503_wave_fetch.sv
// ---------------------------------------------------------------------------
// doc5503_wave_fetch
//
// Arbitrates one shared sound-RAM port between DOC wave fetches and host
// accesses. Wave requests always win over host requests.
//
// Ports
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   wave_rd_i, wave_address_i  DOC wave-read strobe and address
//   wave_data_ready_o          one-cycle pulse, wave_data_o valid
//   wave_data_o                wave byte, held until the next wave completion
//   host_req_i .. host_wdata_i host request (level, held until host_ack_o)
//   host_ack_o, host_rdata_o   host completion pulse and held read data
//   mem_req_o .. mem_wdata_o   memory request, held until ack or timeout
//   mem_ack_i, mem_rdata_i     memory completion, data valid with ack
//   busy_o                     high whenever an access is in flight
//   overrun_o                  sticky: a pending wave request was replaced
// ---------------------------------------------------------------------------
module doc5503_wave_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'h80
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        wave_rd_i,
  input  logic [15:0] wave_address_i,
  output logic        wave_data_ready_o,
  output logic [7:0]  wave_data_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [15:0] host_addr_i,
  input  logic [7:0]  host_wdata_i,
  output logic        host_ack_o,
  output logic [7:0]  host_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAVE = 2'd1,
    HOST = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic        pend_q,       pend_d;
  logic [15:0] pend_addr_q,  pend_addr_d;
  logic        overrun_q,    overrun_d;
  logic        mem_req_q,    mem_req_d;
  logic        mem_we_q,     mem_we_d;
  logic [15:0] mem_addr_q,   mem_addr_d;
  logic [7:0]  mem_wdata_q,  mem_wdata_d;
  logic [CNT_W-1:0] tmo_q,   tmo_d;
  logic [7:0]  wave_data_q,  wave_data_d;
  logic        wave_ready_q, wave_ready_d;
  logic        host_ack_q,   host_ack_d;
  logic [7:0]  host_rdata_q, host_rdata_d;

  logic issue_wave;
  logic timeout_hit;

  // Counter is compared one below the limit so mem_req_o stays high for
  // exactly TIMEOUT_CYCLES cycles before the access is abandoned.
  assign timeout_hit = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    overrun_d    = overrun_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    tmo_d        = tmo_q;
    wave_data_d  = wave_data_q;
    wave_ready_d = 1'b0;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;

    // The first cycle in WAVE launches the request and consumes the
    // pending entry; a strobe in that same cycle is a fresh request,
    // not an overrun.
    issue_wave = (state_q == WAVE) && !mem_req_q;

    if (issue_wave) begin
      pend_d = 1'b0;
    end
    if (wave_rd_i) begin
      pend_d      = 1'b1;
      pend_addr_d = wave_address_i;
      if (pend_q && !issue_wave) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // host_ack_q blocks a host requester that has not yet dropped its
        // level request from being served twice.
        if (pend_q || wave_rd_i) begin
          state_d = WAVE;
        end else if (host_req_i && !host_ack_q) begin
          state_d     = HOST;
          mem_we_d    = host_we_i;
          mem_addr_d  = host_addr_i;
          mem_wdata_d = host_wdata_i;
        end
      end

      WAVE: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pend_addr_q;
          tmo_d      = '0;
        end else if (mem_ack_i) begin
          wave_data_d  = mem_rdata_i;
          wave_ready_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end else if (timeout_hit) begin
          wave_data_d  = TIMEOUT_DATA;
          wave_ready_d = 1'b1;
          mem_req_d    = 1'b0;
          tmo_d        = tmo_q + CNT_W'(1);
          state_d      = IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      HOST: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          tmo_d     = '0;
        end else if (mem_ack_i || timeout_hit) begin
          host_ack_d = 1'b1;
          mem_req_d  = 1'b0;
          if (!mem_we_q) begin
            host_rdata_d = mem_ack_i ? mem_rdata_i : 8'h00;
          end
          if (!mem_ack_i) begin
            tmo_d = tmo_q + CNT_W'(1);
          end
          // A wave request that arrived during the host access goes
          // straight to WAVE without a detour through IDLE.
          state_d = (pend_q || wave_rd_i) ? WAVE : IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      overrun_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tmo_q        <= '0;
      wave_data_q  <= '0;
      wave_ready_q <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      overrun_q    <= overrun_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tmo_q        <= tmo_d;
      wave_data_q  <= wave_data_d;
      wave_ready_q <= wave_ready_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign wave_data_ready_o = wave_ready_q;
  assign wave_data_o       = wave_data_q;
  assign host_ack_o        = host_ack_q;
  assign host_rdata_o      = host_rdata_q;
  assign mem_req_o         = mem_req_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;
  assign busy_o            = (state_q != IDLE);
  assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_doc5503_wave_fetch.sv
// ---------------------------------------------------------------------------
// tb_doc5503_wave_fetch
//
// Scoreboard bench for doc5503_wave_fetch. A sound-RAM model answers memory
// requests (addresses 0xFxxx never answer); a reference RAM predicts every
// wave byte and host completion, which a monitor checks on each pulse.
// ---------------------------------------------------------------------------
module tb_doc5503_wave_fetch;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        wave_rd_i = 1'b0;
  logic [15:0] wave_address_i = '0;
  logic        wave_data_ready_o;
  logic [7:0]  wave_data_o;
  logic        host_req_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [15:0] host_addr_i = '0;
  logic [7:0]  host_wdata_i = '0;
  logic        host_ack_o;
  logic [7:0]  host_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic        busy_o;
  logic        overrun_o;

  always #5 clk_i = ~clk_i;

  doc5503_wave_fetch #(.TIMEOUT_CYCLES(64), .TIMEOUT_DATA(8'h80)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .wave_rd_i(wave_rd_i), .wave_address_i(wave_address_i),
    .wave_data_ready_o(wave_data_ready_o), .wave_data_o(wave_data_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] wave_q[$];
  logic [7:0] host_q[$];
  logic [7:0] ref_ram [logic [15:0]];
  logic [7:0] last_wave = 8'h00;
  logic [7:0] last_host_rdata = 8'h00;

  // memory model controls
  bit  mem_enable = 1'b1;
  bit  mem_never = 1'b0;
  int  mem_lat_fixed = -1;
  int  spur_req = 0;
  int  spur_seen = 0;
  logic [7:0]  mem_ram [logic [15:0]];
  logic [15:0] log_addr[$];
  logic        log_we[$];
  logic [7:0]  log_wdata[$];
  bit  in_acc = 1'b0;
  bit  acc_never = 1'b0;
  int  acc_cnt = 0;
  int  acc_lat = 0;

  function automatic logic [7:0] seed_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_ram.exists(a)) return ref_ram[a];
    return seed_byte(a);
  endfunction

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // sound-RAM model: random or fixed latency, silent for 0xFxxx
  always @(negedge clk_i) begin
    mem_ack_i = 1'b0;
    if (spur_req != spur_seen && !mem_req_o) begin
      spur_seen   = spur_req;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 8'h77;
    end else if (!reset_n_i || !mem_req_o || !mem_enable) begin
      in_acc = 1'b0;
    end else begin
      if (!in_acc) begin
        in_acc    = 1'b1;
        acc_cnt   = 0;
        acc_lat   = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 4));
        acc_never = mem_never || (mem_addr_o[15:12] == 4'hF);
        log_addr.push_back(mem_addr_o);
        log_we.push_back(mem_we_o);
        log_wdata.push_back(mem_wdata_o);
      end
      if (!acc_never) begin
        if (acc_cnt == acc_lat) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) mem_ram[mem_addr_o] = mem_wdata_o;
          else mem_rdata_i = mem_ram.exists(mem_addr_o) ? mem_ram[mem_addr_o] : seed_byte(mem_addr_o);
          in_acc = 1'b0;
        end else begin
          acc_cnt++;
        end
      end
    end
  end

  // monitor: every completion pulse is matched against the scoreboard
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (wave_data_ready_o) begin
        if (wave_q.size() == 0) begin
          n_vec++; n_err++;
          $display("[TB] FAIL wave_unexpected: got pulse with data %h, expected no pulse", wave_data_o);
        end else begin
          logic [7:0] e;
          e = wave_q.pop_front();
          check_output("wave_data", 16'(wave_data_o), 16'(e));
        end
      end
      if (host_ack_o) begin
        if (host_q.size() == 0) begin
          n_vec++; n_err++;
          $display("[TB] FAIL host_unexpected: got ack with rdata %h, expected no ack", host_rdata_o);
        end else begin
          logic [7:0] e;
          e = host_q.pop_front();
          check_output("host_rdata", 16'(host_rdata_o), 16'(e));
        end
      end
    end
  end

  task automatic wait_wave_done(input int bound);
    int n = 0;
    while (wave_q.size() != 0 && n < bound) begin
      @(negedge clk_i); #1; n++;
    end
    if (wave_q.size() != 0) begin
      n_vec++; n_err++;
      $display("[TB] FAIL wave_timeout: %0d responses outstanding, expected 0", wave_q.size());
      wave_q.delete();
    end
  endtask

  task automatic wait_host_done(input int bound);
    int n = 0;
    while (host_q.size() != 0 && n < bound) begin
      @(negedge clk_i); #1; n++;
    end
    if (host_q.size() != 0) begin
      n_vec++; n_err++;
      $display("[TB] FAIL host_timeout: %0d acks outstanding, expected 0", host_q.size());
      host_q.delete();
    end
  endtask

  task automatic wave_strobe(input logic [15:0] a, input bit push, input logic [7:0] e);
    @(negedge clk_i);
    wave_rd_i      = 1'b1;
    wave_address_i = a;
    if (push) begin
      wave_q.push_back(e);
      last_wave = e;
    end
    @(negedge clk_i);
    wave_rd_i = 1'b0;
  endtask

  task automatic host_access(input logic we, input logic [15:0] a, input logic [7:0] d);
    bit tmo;
    logic [7:0] e;
    tmo = mem_never || (a[15:12] == 4'hF);
    @(negedge clk_i);
    host_req_i   = 1'b1;
    host_we_i    = we;
    host_addr_i  = a;
    host_wdata_i = d;
    if (we) begin
      e = last_host_rdata;
      if (!tmo) ref_ram[a] = d;
    end else begin
      e = tmo ? 8'h00 : ref_read(a);
      last_host_rdata = e;
    end
    host_q.push_back(e);
    wait_host_done(300);
    host_req_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"},    16'(busy_o), 16'h0);
    check_output({tag, "_memreq"},  16'(mem_req_o), 16'h0);
    check_output({tag, "_memwe"},   16'(mem_we_o), 16'h0);
    check_output({tag, "_memaddr"}, mem_addr_o, 16'h0);
    check_output({tag, "_memwd"},   16'(mem_wdata_o), 16'h0);
    check_output({tag, "_wdata"},   16'(wave_data_o), 16'h0);
    check_output({tag, "_hrdata"},  16'(host_rdata_o), 16'h0);
    check_output({tag, "_overrun"}, 16'(overrun_o), 16'h0);
    check_output({tag, "_wready"},  16'(wave_data_ready_o), 16'h0);
    check_output({tag, "_hack"},    16'(host_ack_o), 16'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int lat;
    int cnt;
    logic [15:0] seen_addr;
    logic        seen_we;

    // reset state
    #1 reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset");
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // basic wave fetch, 3-cycle latency; memory primed by a host write
    host_access(1'b1, 16'h1234, 8'h5A);
    mem_lat_fixed = 0;
    @(negedge clk_i);
    wave_rd_i      = 1'b1;
    wave_address_i = 16'h1234;
    wave_q.push_back(ref_read(16'h1234));
    last_wave = ref_read(16'h1234);
    lat = -1;
    seen_addr = '0;
    seen_we   = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i); #1;
      wave_rd_i = 1'b0;
      if (mem_req_o) begin
        seen_addr = mem_addr_o;
        seen_we   = mem_we_o;
      end
      if (wave_data_ready_o && lat < 0) lat = c;
    end
    check_output("wave_latency", 16'(lat), 16'd3);
    check_output("wave_memaddr", seen_addr, 16'h1234);
    check_output("wave_memwe", 16'(seen_we), 16'h0);
    check_output("wave_hold", 16'(wave_data_o), 16'h5A);
    mem_lat_fixed = -1;

    // wave and host in the same cycle: wave first, then host write
    base = log_addr.size();
    @(negedge clk_i);
    wave_rd_i      = 1'b1;
    wave_address_i = 16'h0200;
    host_req_i     = 1'b1;
    host_we_i      = 1'b1;
    host_addr_i    = 16'h0010;
    host_wdata_i   = 8'hAA;
    wave_q.push_back(ref_read(16'h0200));
    last_wave = ref_read(16'h0200);
    host_q.push_back(last_host_rdata);
    ref_ram[16'h0010] = 8'hAA;
    @(negedge clk_i);
    wave_rd_i = 1'b0;
    wait_wave_done(100);
    wait_host_done(100);
    host_req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check_output("prio_count", 16'(log_addr.size() - base), 16'd2);
    check_output("prio_first_addr", log_addr[base], 16'h0200);
    check_output("prio_first_we", 16'(log_we[base]), 16'h0);
    check_output("prio_second_addr", log_addr[base+1], 16'h0010);
    check_output("prio_second_we", 16'(log_we[base+1]), 16'h1);
    check_output("prio_second_wdata", 16'(log_wdata[base+1]), 16'hAA);

    // spurious ack while idle changes nothing
    spur_req++;
    repeat (4) @(negedge clk_i);
    check_output("spur_wdata", 16'(wave_data_o), 16'(last_wave));
    check_output("spur_hrdata", 16'(host_rdata_o), 16'(last_host_rdata));
    check_output("spur_busy", 16'(busy_o), 16'h0);
    check_output("spur_memreq", 16'(mem_req_o), 16'h0);

    // memory never answers a wave read
    mem_never = 1'b1;
    wave_strobe(16'h0300, 1'b1, 8'h80);
    cnt = 0;
    for (int n = 0; n < 200 && wave_q.size() != 0; n++) begin
      @(negedge clk_i); #1;
      if (mem_req_o) cnt++;
    end
    wait_wave_done(5);
    check_output("tmo_req_cycles", 16'(cnt), 16'd64);
    check_output("tmo_busy", 16'(busy_o), 16'h0);
    mem_never = 1'b0;

    // two wave strobes during a long host read: only the second is fetched
    mem_lat_fixed = 20;
    base = log_addr.size();
    fork
      host_access(1'b0, 16'h8001, 8'h00);
      begin
        for (int n = 0; n < 20 && !mem_req_o; n++) @(negedge clk_i);
        wave_strobe(16'h0100, 1'b0, 8'h00);
        repeat (2) @(negedge clk_i);
        wave_strobe(16'h0101, 1'b1, ref_read(16'h0101));
        check_output("overrun_set", 16'(overrun_o), 16'h1);
      end
    join
    wait_wave_done(300);
    mem_lat_fixed = -1;
    check_output("overrun_count", 16'(log_addr.size() - base), 16'd2);
    check_output("overrun_fetch", log_addr[base+1], 16'h0101);
    check_output("overrun_sticky", 16'(overrun_o), 16'h1);

    // reset in the middle of a host read
    mem_enable = 1'b0;
    @(negedge clk_i);
    host_req_i  = 1'b1;
    host_we_i   = 1'b0;
    host_addr_i = 16'h8003;
    repeat (5) @(negedge clk_i);
    check_output("mid_memreq", 16'(mem_req_o), 16'h1);
    check_output("mid_busy", 16'(busy_o), 16'h1);
    host_req_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1 check_reset_values("midreset");
    last_host_rdata = 8'h00;
    last_wave       = 8'h00;
    repeat (2) @(negedge clk_i);
    reset_n_i  = 1'b1;
    mem_enable = 1'b1;
    repeat (2) @(negedge clk_i);
    host_access(1'b0, 16'h8003, 8'h00);

    // randomized concurrent traffic
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [15:0] a;
          if ($urandom_range(0, 15) == 0) a = 16'hF000 | 16'($urandom_range(0, 4095));
          else a = 16'($urandom_range(0, 32767));
          wave_strobe(a, 1'b1, (a[15:12] == 4'hF) ? 8'h80 : ref_read(a));
          wait_wave_done(300);
          repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          logic [15:0] a;
          if ($urandom_range(0, 15) == 0) a = 16'hF000 | 16'($urandom_range(0, 255));
          else a = 16'h8000 | 16'($urandom_range(0, 15));
          host_access(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 4)) @(negedge clk_i);
        end
      end
    join
    repeat (5) @(negedge clk_i);
    check_output("final_overrun", 16'(overrun_o), 16'h0);
    check_output("final_busy", 16'(busy_o), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
